// File: rtl/nvram_uploader.sv
// Serves HPS upload reads from the 1K x 4 CMOS RAM, packing nibble pairs into bytes.
// Optional save-request flag enabled by defining NVRAM_DIRTY_EN.
module nvram_uploader #(
  parameter int UPLOAD_INDEX = 4,
  parameter int RD_LATENCY   = 1,
  parameter int IMAGE_BYTES  = 512
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [15:0] ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [9:0]  ram_addr,
  output logic        ram_rd,
  input  logic [3:0]  ram_q,
  input  logic        ram_busy,
  input  logic        cpu_cmos_we,
  output logic        nvram_dirty
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_LO,
    WAIT_LO,
    ISSUE_HI,
    WAIT_HI
  } state_t;

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);
  localparam logic [8:0] LAST_N   = 9'(IMAGE_BYTES - 1);

  state_t     state_q, state_d;
  logic [7:0] din_q, din_d;
  logic       wait_q, wait_d;
  logic [9:0] addr_q, addr_d;
  logic [8:0] n_q, n_d;
  logic [3:0] lo_q, lo_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rd_c;
  logic       last_hit;
  logic       session;
  logic       oob;

  assign session = ioctl_upload && (ioctl_index == 16'(UPLOAD_INDEX));
  assign oob     = ioctl_addr >= 25'(IMAGE_BYTES);

  always_comb begin
    state_d  = state_q;
    din_d    = din_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    n_d      = n_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    rd_c     = 1'b0;
    last_hit = 1'b0;
    // Losing the session mid-request abandons it; the last byte stays visible.
    if (!session && state_q != IDLE) begin
      state_d = IDLE;
      wait_d  = 1'b0;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (session && ioctl_rd) begin
            if (oob) begin
              din_d = 8'hFF;
            end else begin
              wait_d  = 1'b1;
              n_d     = ioctl_addr[8:0];
              addr_d  = {ioctl_addr[8:0], 1'b0};
              state_d = ISSUE_LO;
            end
          end
        end
        ISSUE_LO: begin
          if (!ram_busy) begin
            rd_c    = 1'b1;
            cnt_d   = 3'd0;
            state_d = WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (cnt_q == LAT_LAST) begin
            lo_d    = ram_q;
            addr_d  = {n_q, 1'b1};
            cnt_d   = 3'd0;
            state_d = ISSUE_HI;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        ISSUE_HI: begin
          if (!ram_busy) begin
            rd_c    = 1'b1;
            cnt_d   = 3'd0;
            state_d = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (cnt_q == LAT_LAST) begin
            din_d    = {ram_q, lo_q};
            wait_d   = 1'b0;
            cnt_d    = 3'd0;
            last_hit = (n_q == LAST_N);
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
          wait_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      addr_q  <= 10'd0;
      n_q     <= 9'd0;
      lo_q    <= 4'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign ram_addr   = addr_q;
  assign ram_rd     = rd_c;

`ifdef NVRAM_DIRTY_EN
  logic sess_q, sess_d;
  logic done_last_q, done_last_d;
  logic dirty_q, dirty_d;
  logic fall;

  assign fall = sess_q && !session;

  always_comb begin
    sess_d      = session;
    done_last_d = done_last_q | last_hit;
    dirty_d     = dirty_q;
    if (fall) begin
      done_last_d = 1'b0;
    end
    // A CPU write in the clearing cycle must win: the image is stale again.
    if (cpu_cmos_we) begin
      dirty_d = 1'b1;
    end else if (fall && done_last_q) begin
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sess_q      <= 1'b0;
      done_last_q <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      sess_q      <= sess_d;
      done_last_q <= done_last_d;
      dirty_q     <= dirty_d;
    end
  end

  assign nvram_dirty = dirty_q;
`else
  logic unused_dirty_inputs;
  assign unused_dirty_inputs = ^{cpu_cmos_we, last_hit};
  assign nvram_dirty = 1'b0;
`endif

endmodule

// File: tb/tb_nvram_uploader.sv
// Directed bench for nvram_uploader with a per-cycle schedule model and RAM model.
// Define NVRAM_DIRTY_EN for both bench and design to exercise the save flag.
module tb_nvram_uploader;

  localparam int L = 1;
`ifdef NVRAM_DIRTY_EN
  localparam logic DIRTY_ON = 1'b1;
`else
  localparam logic DIRTY_ON = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [15:0] ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [9:0]  ram_addr;
  logic        ram_rd;
  logic [3:0]  ram_q = 4'h0;
  logic        ram_busy;
  logic        cpu_cmos_we;
  logic        nvram_dirty;

  always #5 clk_sys = ~clk_sys;

  nvram_uploader #(
    .UPLOAD_INDEX(4),
    .RD_LATENCY(L),
    .IMAGE_BYTES(512)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .ram_addr(ram_addr),
    .ram_rd(ram_rd),
    .ram_q(ram_q),
    .ram_busy(ram_busy),
    .cpu_cmos_we(cpu_cmos_we),
    .nvram_dirty(nvram_dirty)
  );

  logic [3:0] mem [1024];

  always @(posedge clk_sys) begin
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  int checks = 0;
  int passes = 0;

  logic       chk_en = 1'b0;
  logic [7:0] e_din;
  logic       e_wait, e_rd, e_dirty, e_addr_chk;
  logic [9:0] e_addr;
  logic [7:0] prev_din;
  logic       nxt_dirty, sess_prev, saw_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("din", 32'(ioctl_din), 32'(e_din));
      chk("wait", 32'(ioctl_wait), 32'(e_wait));
      chk("ram_rd", 32'(ram_rd), 32'(e_rd));
      chk("dirty", 32'(nvram_dirty), 32'(e_dirty));
      if (e_addr_chk) chk("ram_addr", 32'(ram_addr), 32'(e_addr));
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Save-flag model: set by CPU writes, cleared when a session that read
  // the last byte ends.
  task automatic cyc_model(input logic sess_now, input logic we,
                           input logic comp_last, input logic rst_now);
    logic fall;
    e_dirty = nxt_dirty;
    if (rst_now) begin
      e_dirty   = 1'b0;
      nxt_dirty = 1'b0;
      sess_prev = 1'b0;
      saw_last  = 1'b0;
    end else begin
      fall = sess_prev && !sess_now;
      if (DIRTY_ON) nxt_dirty = we ? 1'b1 : (fall && saw_last) ? 1'b0 : e_dirty;
      else nxt_dirty = 1'b0;
      if (fall) saw_last = 1'b0;
      if (comp_last) saw_last = 1'b1;
      sess_prev = sess_now;
    end
  endtask

  task automatic idle(input int ncyc, input logic up, input logic we_first);
    for (int i = 0; i < ncyc; i++) begin
      step();
      ioctl_upload = up;
      ioctl_index  = 16'd4;
      ioctl_rd     = 1'b0;
      ram_busy     = 1'b0;
      reset        = 1'b0;
      cpu_cmos_we  = (i == 0) && we_first;
      e_wait = 1'b0;
      e_rd = 1'b0;
      e_din = prev_din;
      e_addr_chk = 1'b0;
      cyc_model(up, cpu_cmos_we, 1'b0, 1'b0);
    end
  endtask

  task automatic run_req(input logic [24:0] addr, input logic [15:0] idx,
                         input logic [31:0] busy, input int abort_at,
                         input int reset_at, input bit dup,
                         output int done_k);
    logic [8:0] n;
    bit sess, acc, up, r, comp;
    int i1, i2, d, last, k;
    n = addr[8:0];
    sess = (idx == 16'd4);
    acc = sess && (addr < 25'd512);
    i1 = -1; i2 = -1; d = 1;
    if (acc) begin
      k = 1;
      while (busy[k]) k++;
      i1 = k;
      k = i1 + L + 1;
      while (busy[k]) k++;
      i2 = k;
      d = i2 + L + 1;
    end
    last = reset_at > 0 ? reset_at + 1 : abort_at > 0 ? abort_at + 1 : acc ? d + 1 : 2;
    done_k = -1;
    for (int c = 0; c <= last; c++) begin
      step();
      if (c >= 1 && done_k < 0 && ioctl_wait == 1'b0) done_k = c;
      up = !(abort_at > 0 && c >= abort_at);
      r = (reset_at > 0 && c == reset_at);
      ioctl_upload = up;
      ioctl_index  = idx;
      ioctl_rd     = (c == 0) || (dup && c == 2);
      ioctl_addr   = (dup && c == 2) ? {16'h0, ~n} : addr;
      ram_busy     = busy[c];
      cpu_cmos_we  = 1'b0;
      reset        = r;
      e_addr_chk = 1'b0;
      comp = 1'b0;
      if (reset_at > 0 && c >= reset_at) begin
        prev_din = 8'h00;
        e_din = 8'h00;
        e_wait = 1'b0;
        e_rd = 1'b0;
        e_addr = 10'd0;
        e_addr_chk = 1'b1;
      end else if (!acc) begin
        if (c >= 1 && sess) prev_din = 8'hFF;
        e_din = prev_din;
        e_wait = 1'b0;
        e_rd = 1'b0;
      end else if (abort_at > 0 && c >= abort_at) begin
        e_wait = (c == abort_at);
        e_rd = 1'b0;
        e_din = prev_din;
      end else begin
        e_wait = (c >= 1) && (c < d);
        e_rd = (c == i1) || (c == i2);
        if (e_rd) begin
          e_addr = {n, c == i2};
          e_addr_chk = 1'b1;
        end
        if (c == d) prev_din = {mem[{n, 1'b1}], mem[{n, 1'b0}]};
        e_din = prev_din;
        comp = (c == d - 1) && (n == 9'd511);
      end
      cyc_model(up && idx == 16'd4, 1'b0, comp, r);
    end
  endtask

  initial begin
    int dk;
    for (int i = 0; i < 1024; i++) mem[i] = 4'($urandom_range(0, 15));
    mem[0] = 4'h3;    mem[1] = 4'hA;
    mem[1022] = 4'h1; mem[1023] = 4'hF;
    mem[4] = 4'h7;    mem[5] = 4'h2;
    mem[12] = 4'hC;   mem[13] = 4'h5;

    reset = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index = 16'd0;
    ioctl_rd = 1'b0;
    ioctl_addr = 25'd0;
    ram_busy = 1'b0;
    cpu_cmos_we = 1'b0;
    prev_din = 8'h00;
    nxt_dirty = 1'b0;
    sess_prev = 1'b0;
    saw_last = 1'b0;

    step();
    e_din = 8'h00; e_wait = 1'b0; e_rd = 1'b0;
    e_addr = 10'd0; e_addr_chk = 1'b1;
    cyc_model(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_addr", 32'(ram_addr), 32'h0);
    idle(2, 1'b1, 1'b0);

    run_req(25'd0, 16'd4, 32'h0, 0, 0, 1'b0, dk);
    chk("lat_a3", 32'(dk), 32'd5);
    chk("din_a3", 32'(ioctl_din), 32'hA3);

    run_req(25'd511, 16'd4, 32'h0, 0, 0, 1'b0, dk);
    chk("din_f1", 32'(ioctl_din), 32'hF1);

    run_req(25'd600, 16'd4, 32'h0, 0, 0, 1'b0, dk);
    chk("oob_lat", 32'(dk), 32'd1);
    chk("oob_din", 32'(ioctl_din), 32'hFF);

    run_req(25'h1000002, 16'd4, 32'h0, 0, 0, 1'b0, dk);
    chk("hi_oob_din", 32'(ioctl_din), 32'hFF);

    run_req(25'd2, 16'd4, 32'hE, 0, 0, 1'b0, dk);
    chk("busy_lat", 32'(dk), 32'd8);
    chk("busy_din", 32'(ioctl_din), 32'h27);

    run_req(25'd3, 16'd4, 32'h0, 2, 0, 1'b0, dk);
    chk("abort_din", 32'(ioctl_din), 32'h27);
    chk("abort_wait", 32'(ioctl_wait), 32'h0);

    run_req(25'd4, 16'd4, 32'h0, 0, 3, 1'b0, dk);
    chk("rst_mid_din", 32'(ioctl_din), 32'h00);

    run_req(25'd5, 16'd0, 32'h0, 0, 0, 1'b0, dk);
    chk("idx0_wait", 32'(ioctl_wait), 32'h0);

    run_req(25'd6, 16'd4, 32'h0, 0, 0, 1'b1, dk);
    chk("dup_din", 32'(ioctl_din), 32'h5C);

    idle(2, 1'b1, 1'b1);
    chk("dirty_set", 32'(nvram_dirty), 32'(DIRTY_ON));
    for (int a = 0; a < 512; a++)
      run_req(25'(a), 16'd4, 32'h0, 0, 0, 1'b0, dk);
    idle(3, 1'b0, 1'b0);
    chk("dirty_clr", 32'(nvram_dirty), 32'h0);

    idle(2, 1'b1, 1'b1);
    for (int a = 0; a < 10; a++)
      run_req(25'(a), 16'd4, 32'h0, 0, 0, 1'b0, dk);
    idle(3, 1'b0, 1'b0);
    chk("dirty_keep", 32'(nvram_dirty), 32'(DIRTY_ON));

    step();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
